issue_order_arb: RTL and testbench
==================================

# issue_order_arb

Parametrised N-slot issue-ordering and shared-MDU arbitration stage at the head of EX, between the ID/EX register and the ALUs/multiply-divide unit. It squashes younger slots behind an older load/store or branch, and NOPs slot 0 for one cycle after a forwarding stall. It serialises multiple MUL/DIV ops from one bundle onto the single shared MDU, holding the bundle upstream until all MDU ops have issued.

## Interface
Parameters:
- ISSUE_W, 2: number of issue slots (2..4); slot 0 is oldest.
- OP_W, `ALU_OP_WIDTH: ALU opcode width; opcode 0 is NOP.
- DATA_W, `DATA_WIDTH: operand width.
- MUL_OP_MIN, `ALU_MUL: opcodes >= this value are MDU ops.

Ports (slot i occupies bits [i*W +: W] of packed buses):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_in  in  ISSUE_W*OP_W  per-slot opcode from ID/EX.
- s1_in, s2_in  in  ISSUE_W*DATA_W  per-slot operands.
- ldst_flag, branch_flag  in  ISSUE_W  per-slot load/store and branch flags.
- fwd_stall  in  1  forwarding stall; slot 0 is invalid in the following cycle.
- mdu_busy  in  1  shared MDU cannot accept an op this cycle.
- mem_lden  in  1  memory load enable from EX.
- op_out  out  ISSUE_W*OP_W  per-slot opcode to the ALUs.
- mdu_valid  out  1  MDU op issued this cycle.
- mdu_op  out  OP_W; mdu_s1, mdu_s2  out  DATA_W  MDU op and operands.
- mdu_slot  out  ISSUE_W  one-hot source slot of the MDU op.
- hold_req  out  1  freezes ID/EX; the same bundle is re-presented next cycle.
- mem_lden_out  out  1  gated load enable.

## Operation
- nop0 register: nop0 <= fwd_stall every cycle; reset 0. When nop0=1, slot 0 is treated as opcode 0.
- Live slot i: slot i is not forced NOP and no older slot j<i has ldst_flag[j] or branch_flag[j]. Non-live slots output op_out=0.
- Eligible mask E: live slots with op >= MUL_OP_MIN. MDU ops never appear on op_out; they go only to the MDU port.
- FSM state IDLE. Registered pending mask P (ISSUE_W bits) is reset to 0.
  - E=0: op_out = live non-MDU ops; mdu_valid=0; hold_req=0.
  - E!=0 and mdu_busy=1: all op_out=0; mdu_valid=0; hold_req=1; FSM stays IDLE. The whole bundle replays next cycle.
  - E!=0 and mdu_busy=0: op_out = live non-MDU ops; the oldest slot in E is issued to the MDU (mdu_valid=1, with its op and operands).
    - If E has one bit set: hold_req=0.
    - Otherwise: P <= E minus the issued bit; hold_req=1; next state DRAIN.
- FSM state DRAIN. Non-MDU ops already executed, so all op_out=0.
  - mdu_busy=1: no issue; hold_req=1.
  - mdu_busy=0: the oldest slot in P is issued, using operands taken live from s1_in/s2_in. Upstream guarantees these are stable while hold_req=1. That bit is cleared from P.
  - hold_req=1 unless this issue empties P. When P empties: hold_req=0 and next state is IDLE.
- mem_lden_out = mem_lden in IDLE; 0 in DRAIN and during the IDLE busy-replay cycle.
- Squash and nop0 evaluation is not applied in DRAIN; P was fixed at entry.

## Timing
- All outputs are combinational from inputs and state, with zero latency. State, P and nop0 update at posedge clk.
- While rst=1, every output is 0, state is IDLE, P=0 and nop0=0. Reset asserted mid-DRAIN abandons the pending ops. Upstream flushes on reset.
- A bundle with k MDU ops and no busy cycles occupies k cycles. hold_req is high for the first k-1 of them.
- Each mdu_busy cycle adds exactly one cycle, with no issue in that cycle.
- At most one mdu_valid per cycle. MDU issue order is strictly oldest slot first.
- fwd_stall asserted in cycle t NOPs slot 0 in cycle t+1 only, unless fwd_stall is also asserted in cycle t+1.
- Simultaneous fwd_stall and entry into DRAIN: nop0 still updates. It has no effect until the FSM is back in IDLE.

## Test plan
- ISSUE_W=2, MUL_OP_MIN=16. op_in={slot1=3, slot0=5}, ldst_flag=2'b01 -> op_out slot0=5, slot1=0; mdu_valid=0; hold_req=0.
- fwd_stall=1 at cycle t; op_in={7,4} at t+1 -> op_out={7,0} at t+1. With fwd_stall=0 at t+1, op_out={7,4} at t+2.
- op_in={17,16}, operands s1=0x11/0x22, mdu_busy=0 -> cycle 0: mdu_slot=01, mdu_op=16, mdu_s1=0x11, hold_req=1. Cycle 1 (DRAIN): mdu_slot=10, mdu_op=17, mdu_s1=0x22, hold_req=0, op_out=0. Cycle 2: FSM in IDLE.
- ISSUE_W=4, op_in={18,2,17,16}, mdu_busy high only on the second cycle -> MDU issues slot0, then a stall cycle, then slot1, then slot3. hold_req=1,1,1,0. op_out slot2=2 only in the first cycle.
- mdu_busy=1 with op_in={3,16} -> op_out=0, mdu_valid=0, hold_req=1, mem_lden_out=0. After busy drops: op_out slot1=3, mdu slot0 issues, hold_req=0.
- Assert rst during DRAIN -> all outputs 0 immediately; after release the FSM is in IDLE with P=0.

Source files
------------

// File: rtl/issue_order_if.sv
// Issue-stage bundle interface: per-slot ops/operands/flags in, squashed ops and
// the single shared-MDU issue port out.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface issue_order_if #(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned OP_W    = `ALU_OP_WIDTH,
    parameter int unsigned DATA_W  = `DATA_WIDTH
);
    logic [ISSUE_W*OP_W-1:0]   op_in;
    logic [ISSUE_W*DATA_W-1:0] s1_in;
    logic [ISSUE_W*DATA_W-1:0] s2_in;
    logic [ISSUE_W-1:0]        ldst_flag;
    logic [ISSUE_W-1:0]        branch_flag;
    logic                      fwd_stall;
    logic                      mdu_busy;
    logic                      mem_lden;
    logic [ISSUE_W*OP_W-1:0]   op_out;
    logic                      mdu_valid;
    logic [OP_W-1:0]           mdu_op;
    logic [DATA_W-1:0]         mdu_s1;
    logic [DATA_W-1:0]         mdu_s2;
    logic [ISSUE_W-1:0]        mdu_slot;
    logic                      hold_req;
    logic                      mem_lden_out;

    modport slave (
        input  op_in, s1_in, s2_in, ldst_flag, branch_flag, fwd_stall, mdu_busy, mem_lden,
        output op_out, mdu_valid, mdu_op, mdu_s1, mdu_s2, mdu_slot, hold_req, mem_lden_out
    );

    modport master (
        output op_in, s1_in, s2_in, ldst_flag, branch_flag, fwd_stall, mdu_busy, mem_lden,
        input  op_out, mdu_valid, mdu_op, mdu_s1, mdu_s2, mdu_slot, hold_req, mem_lden_out
    );
endinterface

// File: rtl/issue_order_arb.sv
// Head-of-EX issue ordering: squashes slots behind older ld/st or branches, NOPs slot 0
// after a forwarding stall, and serialises a bundle's MUL/DIV ops onto the shared MDU.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_MUL
`define ALU_MUL 16
`endif

module issue_order_arb #(
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned OP_W       = `ALU_OP_WIDTH,
    parameter int unsigned DATA_W     = `DATA_WIDTH,
    parameter int unsigned MUL_OP_MIN = `ALU_MUL
) (
    input logic          clk,
    input logic          rst,
    issue_order_if.slave bus
);
    localparam logic [OP_W-1:0] MulMin = OP_W'(MUL_OP_MIN);

    typedef enum logic [0:0] {StIdle, StDrain} stateT;

    stateT              stateQ, stateD;
    logic [ISSUE_W-1:0] pendingQ, pendingD;
    logic               nop0Q;

    logic [OP_W-1:0]    slotOp [ISSUE_W];
    logic [ISSUE_W-1:0] live, isMdu, eligible, issueSet, issueOh, remaining;
    logic               blocked, issue;
    int                 issueIdx;

    always_comb begin
        blocked = 1'b0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            slotOp[i] = bus.op_in[i*OP_W +: OP_W];
            if (i == 0 && nop0Q) slotOp[i] = '0;
            isMdu[i] = (slotOp[i] >= MulMin);
            live[i]  = !(i == 0 && nop0Q) && !blocked;
            blocked  = blocked | bus.ldst_flag[i] | bus.branch_flag[i];
        end
        eligible = live & isMdu;
    end

    // In DRAIN the pending mask was frozen at entry; fresh squash/nop0 results are ignored.
    always_comb begin
        issueSet = (stateQ == StDrain) ? pendingQ : eligible;
        issueOh  = '0;
        issueIdx = 0;
        for (int i = int'(ISSUE_W) - 1; i >= 0; i--) begin
            if (issueSet[i]) begin
                issueOh    = '0;
                issueOh[i] = 1'b1;
                issueIdx   = i;
            end
        end
        remaining = issueSet & ~issueOh;
    end

    always_comb begin
        stateD           = stateQ;
        pendingD         = pendingQ;
        issue            = 1'b0;
        bus.op_out       = '0;
        bus.mdu_valid    = 1'b0;
        bus.mdu_op       = '0;
        bus.mdu_s1       = '0;
        bus.mdu_s2       = '0;
        bus.mdu_slot     = '0;
        bus.hold_req     = 1'b0;
        bus.mem_lden_out = 1'b0;
        if (!rst) begin
            unique case (stateQ)
                StIdle: begin
                    if ((|eligible) && bus.mdu_busy) begin
                        bus.hold_req = 1'b1;
                    end else begin
                        for (int i = 0; i < int'(ISSUE_W); i++) begin
                            if (live[i] && !isMdu[i]) bus.op_out[i*OP_W +: OP_W] = slotOp[i];
                        end
                        bus.mem_lden_out = bus.mem_lden;
                        if (|eligible) begin
                            issue = 1'b1;
                            if (|remaining) begin
                                pendingD     = remaining;
                                bus.hold_req = 1'b1;
                                stateD       = StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (bus.mdu_busy) begin
                        bus.hold_req = 1'b1;
                    end else begin
                        issue    = 1'b1;
                        pendingD = remaining;
                        if (|remaining) bus.hold_req = 1'b1;
                        else            stateD       = StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
            if (issue) begin
                bus.mdu_valid = 1'b1;
                bus.mdu_op    = bus.op_in[issueIdx*OP_W +: OP_W];
                bus.mdu_s1    = bus.s1_in[issueIdx*DATA_W +: DATA_W];
                bus.mdu_s2    = bus.s2_in[issueIdx*DATA_W +: DATA_W];
                bus.mdu_slot  = issueOh;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            pendingQ <= '0;
            nop0Q    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pendingQ <= pendingD;
            nop0Q    <= bus.fwd_stall;
        end
    end
endmodule

// File: tb/tb_issue_order_arb.sv
// Directed bench for issue_order_arb (4 slots, 5-bit ops, MDU ops >= 16).
module tb_issue_order_arb;
    localparam int unsigned IW = 4;
    localparam int unsigned OW = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    issue_order_if #(.ISSUE_W(IW), .OP_W(OW), .DATA_W(DW)) bus ();

    issue_order_arb #(.ISSUE_W(IW), .OP_W(OW), .DATA_W(DW), .MUL_OP_MIN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW*OW-1:0] ops4(input int o3, input int o2, input int o1,
                                              input int o0);
        return {OW'(o3), OW'(o2), OW'(o1), OW'(o0)};
    endfunction

    task automatic checkMdu(input string tag, input logic v, input int slot, input int op,
                            input int s1, input logic hold);
        checkEq({tag, ".valid"}, 64'(bus.mdu_valid), 64'(v));
        checkEq({tag, ".slot"}, 64'(bus.mdu_slot), 64'(slot));
        checkEq({tag, ".op"}, 64'(bus.mdu_op), 64'(op));
        checkEq({tag, ".s1"}, 64'(bus.mdu_s1), 64'(s1));
        checkEq({tag, ".hold"}, 64'(bus.hold_req), 64'(hold));
    endtask

    initial begin
        bus.op_in       = ops4(0, 0, 3, 5);
        bus.s1_in       = {32'h04, 32'h03, 32'h22, 32'h11};
        bus.s2_in       = {32'h54, 32'h53, 32'h44, 32'h33};
        bus.ldst_flag   = '0;
        bus.branch_flag = '0;
        bus.fwd_stall   = 1'b0;
        bus.mdu_busy    = 1'b0;
        bus.mem_lden    = 1'b1;
        #1;
        checkEq("rst.op_out", 64'(bus.op_out), 64'h0);
        checkEq("rst.lden", 64'(bus.mem_lden_out), 64'h0);
        checkMdu("rst", 1'b0, 0, 0, 0, 1'b0);

        @(negedge clk) rst = 1'b0;
        bus.ldst_flag = 4'b0001;
        #1;
        checkEq("ldst.op_out", 64'(bus.op_out), 64'h5);
        checkEq("ldst.lden", 64'(bus.mem_lden_out), 64'h1);
        checkMdu("ldst", 1'b0, 0, 0, 0, 1'b0);

        // Branch in slot 1 squashes the younger MDU op in slot 3.
        @(negedge clk);
        bus.ldst_flag   = '0;
        bus.branch_flag = 4'b0010;
        bus.op_in       = ops4(16, 3, 5, 2);
        #1;
        checkEq("br.op_out", 64'(bus.op_out), 64'hA2);
        checkMdu("br", 1'b0, 0, 0, 0, 1'b0);

        @(negedge clk);
        bus.branch_flag = '0;
        bus.op_in       = '0;
        bus.fwd_stall   = 1'b1;
        @(negedge clk);
        bus.fwd_stall = 1'b0;
        bus.op_in     = ops4(0, 0, 7, 4);
        #1 checkEq("nop0.t1", 64'(bus.op_out), 64'hE0);
        @(negedge clk);
        #1 checkEq("nop0.t2", 64'(bus.op_out), 64'hE4);

        // Two MDU ops in slots 0/1.
        @(negedge clk) bus.op_in = ops4(0, 0, 17, 16);
        #1;
        checkMdu("pair.c0", 1'b1, 1, 16, 'h11, 1'b1);
        checkEq("pair.c0.op_out", 64'(bus.op_out), 64'h0);
        checkEq("pair.c0.s2", 64'(bus.mdu_s2), 64'h33);
        @(negedge clk);
        #1;
        checkMdu("pair.c1", 1'b1, 2, 17, 'h22, 1'b0);
        checkEq("pair.c1.op_out", 64'(bus.op_out), 64'h0);
        checkEq("pair.c1.s2", 64'(bus.mdu_s2), 64'h44);
        checkEq("pair.c1.lden", 64'(bus.mem_lden_out), 64'h0);
        @(negedge clk) bus.op_in = ops4(0, 0, 3, 5);
        #1;
        checkEq("pair.c2.op_out", 64'(bus.op_out), 64'h65);
        checkEq("pair.c2.lden", 64'(bus.mem_lden_out), 64'h1);

        // Three MDU ops with one busy cycle while draining.
        @(negedge clk) bus.op_in = ops4(18, 2, 17, 16);
        #1;
        checkMdu("tri.c0", 1'b1, 1, 16, 'h11, 1'b1);
        checkEq("tri.c0.op_out", 64'(bus.op_out), 64'h800);
        @(negedge clk) bus.mdu_busy = 1'b1;
        #1;
        checkMdu("tri.c1", 1'b0, 0, 0, 0, 1'b1);
        checkEq("tri.c1.op_out", 64'(bus.op_out), 64'h0);
        @(negedge clk) bus.mdu_busy = 1'b0;
        #1;
        checkMdu("tri.c2", 1'b1, 2, 17, 'h22, 1'b1);
        checkEq("tri.c2.op_out", 64'(bus.op_out), 64'h0);
        @(negedge clk);
        #1;
        checkMdu("tri.c3", 1'b1, 8, 18, 'h04, 1'b0);
        checkEq("tri.c3.op_out", 64'(bus.op_out), 64'h0);

        // Busy MDU in IDLE replays the whole bundle.
        @(negedge clk);
        bus.op_in    = ops4(0, 0, 3, 16);
        bus.mdu_busy = 1'b1;
        #1;
        checkMdu("busy.c0", 1'b0, 0, 0, 0, 1'b1);
        checkEq("busy.c0.op_out", 64'(bus.op_out), 64'h0);
        checkEq("busy.c0.lden", 64'(bus.mem_lden_out), 64'h0);
        @(negedge clk) bus.mdu_busy = 1'b0;
        #1;
        checkMdu("busy.c1", 1'b1, 1, 16, 'h11, 1'b0);
        checkEq("busy.c1.op_out", 64'(bus.op_out), 64'h60);
        checkEq("busy.c1.lden", 64'(bus.mem_lden_out), 64'h1);

        // Reset asserted mid-DRAIN.
        @(negedge clk) bus.op_in = ops4(0, 0, 17, 16);
        #1 checkMdu("rdr.c0", 1'b1, 1, 16, 'h11, 1'b1);
        @(negedge clk) rst = 1'b1;
        #1;
        checkMdu("rdr.rst", 1'b0, 0, 0, 0, 1'b0);
        checkEq("rdr.rst.op_out", 64'(bus.op_out), 64'h0);
        checkEq("rdr.rst.lden", 64'(bus.mem_lden_out), 64'h0);
        @(negedge clk);
        rst       = 1'b0;
        bus.op_in = ops4(0, 0, 3, 5);
        #1;
        checkEq("rdr.post.op_out", 64'(bus.op_out), 64'h65);
        checkEq("rdr.post.lden", 64'(bus.mem_lden_out), 64'h1);
        checkMdu("rdr.post", 1'b0, 0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
